// File: rtl/mcp_controller.sv
// mcp_controller: Moore control FSM sequencing the multicycle MIPS datapath.
// Ports:
//   clk_i, reset_ni (async, active-low)
//   opcode_i6, zero_i, mem_ready_i       -> decode/branch/memory handshake inputs
//   pc_we_o, pc_branch_o2                -> PC load enable and next-PC select
//   instr_or_data_o, instr_we_o, mem_we_o -> memory address select, IR load, write strobe
//   reg_dst_rtrd_o, mem_to_reg_o, enable_wrf_o -> register-file write controls
//   a_alu_input_o, b_alu_input_o2, alu_alt_ctrl_o2 -> ALU operand/operation selects
//   illegal_o, state_o4, instr_cnt_o     -> status, debug state, retired-instruction count
module mcp_controller #(
    parameter int INSTR_CNT_W = 32
) (
    input  logic                   clk_i,
    input  logic                   reset_ni,
    input  logic [5:0]             opcode_i6,
    input  logic                   zero_i,
    input  logic                   mem_ready_i,
    output logic                   pc_we_o,
    output logic [1:0]             pc_branch_o2,
    output logic                   instr_or_data_o,
    output logic                   instr_we_o,
    output logic                   mem_we_o,
    output logic                   reg_dst_rtrd_o,
    output logic                   mem_to_reg_o,
    output logic                   enable_wrf_o,
    output logic                   a_alu_input_o,
    output logic [1:0]             b_alu_input_o2,
    output logic [1:0]             alu_alt_ctrl_o2,
    output logic                   illegal_o,
    output logic [3:0]             state_o4,
    output logic [INSTR_CNT_W-1:0] instr_cnt_o
);
    localparam logic [3:0] FETCH   = 4'd0;
    localparam logic [3:0] DECODE  = 4'd1;
    localparam logic [3:0] MEMADR  = 4'd2;
    localparam logic [3:0] MEMRD   = 4'd3;
    localparam logic [3:0] MEMWB   = 4'd4;
    localparam logic [3:0] MEMWR   = 4'd5;
    localparam logic [3:0] EXECUTE = 4'd6;
    localparam logic [3:0] ALUWB   = 4'd7;
    localparam logic [3:0] BRANCH  = 4'd8;
    localparam logic [3:0] ADDIEX  = 4'd9;
    localparam logic [3:0] ADDIWB  = 4'd10;
    localparam logic [3:0] JUMP    = 4'd11;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    logic [3:0] state;
    logic [3:0] next;
    logic       retire;

    always_comb begin
        next = FETCH;
        case (state)
            FETCH:   next = mem_ready_i ? DECODE : FETCH;
            DECODE:
                case (opcode_i6)
                    OP_LW, OP_SW:   next = MEMADR;
                    OP_R:           next = EXECUTE;
                    OP_BEQ, OP_BNE: next = BRANCH;
                    OP_ADDI:        next = ADDIEX;
                    OP_J:           next = JUMP;
                    default:        next = FETCH;
                endcase
            MEMADR:  next = (opcode_i6 == OP_SW) ? MEMWR : MEMRD;
            MEMRD:   next = mem_ready_i ? MEMWB : MEMRD;
            MEMWR:   next = mem_ready_i ? FETCH : MEMWR;
            EXECUTE: next = ALUWB;
            ADDIEX:  next = ADDIWB;
            default: next = FETCH;
        endcase
    end

    // Every legal instruction ends by entering FETCH from exactly one of these
    // states; illegal opcodes leave from DECODE and so never count.
    assign retire = (state == MEMWB) || (state == ALUWB) || (state == BRANCH) ||
                    (state == ADDIWB) || (state == JUMP) ||
                    ((state == MEMWR) && mem_ready_i);

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state       <= FETCH;
            instr_cnt_o <= '0;
        end else begin
            state       <= next;
            instr_cnt_o <= instr_cnt_o + INSTR_CNT_W'(retire);
        end
    end

    always_comb begin
        pc_we_o         = 1'b0;
        pc_branch_o2    = 2'b00;
        instr_or_data_o = 1'b0;
        instr_we_o      = 1'b0;
        mem_we_o        = 1'b0;
        reg_dst_rtrd_o  = 1'b0;
        mem_to_reg_o    = 1'b0;
        enable_wrf_o    = 1'b0;
        a_alu_input_o   = 1'b0;
        b_alu_input_o2  = 2'b00;
        alu_alt_ctrl_o2 = 2'b00;
        illegal_o       = 1'b0;
        case (state)
            FETCH: begin
                b_alu_input_o2 = 2'b01;
                pc_we_o        = mem_ready_i;
                instr_we_o     = mem_ready_i;
            end
            DECODE: begin
                b_alu_input_o2 = 2'b11;
                illegal_o      = !(opcode_i6 inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J});
            end
            MEMADR, ADDIEX: begin
                a_alu_input_o  = 1'b1;
                b_alu_input_o2 = 2'b10;
            end
            MEMRD: instr_or_data_o = 1'b1;
            MEMWB: begin
                mem_to_reg_o = 1'b1;
                enable_wrf_o = 1'b1;
            end
            MEMWR: begin
                instr_or_data_o = 1'b1;
                mem_we_o        = 1'b1;
            end
            EXECUTE: begin
                a_alu_input_o   = 1'b1;
                alu_alt_ctrl_o2 = 2'b10;
            end
            ALUWB: begin
                reg_dst_rtrd_o = 1'b1;
                enable_wrf_o   = 1'b1;
            end
            BRANCH: begin
                a_alu_input_o   = 1'b1;
                alu_alt_ctrl_o2 = 2'b01;
                pc_branch_o2    = 2'b01;
                // opcode bit 0 distinguishes bne from beq
                pc_we_o         = opcode_i6[0] ? !zero_i : zero_i;
            end
            ADDIWB: enable_wrf_o = 1'b1;
            JUMP: begin
                pc_branch_o2 = 2'b10;
                pc_we_o      = 1'b1;
            end
            default: ;
        endcase
    end

    assign state_o4 = state;
endmodule

// File: tb/tb_mcp_controller.sv
// tb_mcp_controller: randomized and directed self-checking bench for mcp_controller.
module tb_mcp_controller;
    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_J    = 6'b000010;

    logic       clk_i = 1'b0;
    logic       reset_ni;
    logic [5:0] opcode_i6;
    logic       zero_i;
    logic       mem_ready_i;
    logic       pc_we_o;
    logic [1:0] pc_branch_o2;
    logic       instr_or_data_o;
    logic       instr_we_o;
    logic       mem_we_o;
    logic       reg_dst_rtrd_o;
    logic       mem_to_reg_o;
    logic       enable_wrf_o;
    logic       a_alu_input_o;
    logic [1:0] b_alu_input_o2;
    logic [1:0] alu_alt_ctrl_o2;
    logic       illegal_o;
    logic [3:0] state_o4;
    logic [3:0] instr_cnt_o;
    logic [14:0] outv;

    int n_checks = 0;
    int n_fail   = 0;
    int exp_cnt  = 0;
    int seq[$];
    bit rdq[$];

    always #5 clk_i = ~clk_i;

    mcp_controller #(.INSTR_CNT_W(4)) dut (
        .clk_i(clk_i), .reset_ni(reset_ni), .opcode_i6(opcode_i6), .zero_i(zero_i),
        .mem_ready_i(mem_ready_i), .pc_we_o(pc_we_o), .pc_branch_o2(pc_branch_o2),
        .instr_or_data_o(instr_or_data_o), .instr_we_o(instr_we_o), .mem_we_o(mem_we_o),
        .reg_dst_rtrd_o(reg_dst_rtrd_o), .mem_to_reg_o(mem_to_reg_o),
        .enable_wrf_o(enable_wrf_o), .a_alu_input_o(a_alu_input_o),
        .b_alu_input_o2(b_alu_input_o2), .alu_alt_ctrl_o2(alu_alt_ctrl_o2),
        .illegal_o(illegal_o), .state_o4(state_o4), .instr_cnt_o(instr_cnt_o)
    );

    assign outv = {pc_we_o, pc_branch_o2, instr_or_data_o, instr_we_o, mem_we_o,
                   reg_dst_rtrd_o, mem_to_reg_o, enable_wrf_o, a_alu_input_o,
                   b_alu_input_o2, alu_alt_ctrl_o2, illegal_o};

    function automatic bit legal(logic [5:0] op);
        return op inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J};
    endfunction

    // Output table indexed by state number, same bit order as outv.
    function automatic logic [14:0] exp_out(int st, logic [5:0] op, logic z, logic rdy);
        logic pcwe, iod, iwe, mwe, rd, m2r, wrf, a, ill;
        logic [1:0] pcb, b, alt;
        {pcwe, iod, iwe, mwe, rd, m2r, wrf, a, ill} = '0;
        {pcb, b, alt} = '0;
        case (st)
            0:  begin b = 2'd1; pcwe = rdy; iwe = rdy; end
            1:  begin b = 2'd3; ill = !legal(op); end
            2:  begin a = 1'b1; b = 2'd2; end
            3:  iod = 1'b1;
            4:  begin m2r = 1'b1; wrf = 1'b1; end
            5:  begin iod = 1'b1; mwe = 1'b1; end
            6:  begin a = 1'b1; alt = 2'd2; end
            7:  begin rd = 1'b1; wrf = 1'b1; end
            8:  begin a = 1'b1; alt = 2'd1; pcb = 2'd1; pcwe = op[0] ? !z : z; end
            9:  begin a = 1'b1; b = 2'd2; end
            10: wrf = 1'b1;
            11: begin pcb = 2'd2; pcwe = 1'b1; end
            default: ;
        endcase
        return {pcwe, pcb, iod, iwe, mwe, rd, m2r, wrf, a, b, alt, ill};
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push(int s, bit r);
        seq.push_back(s);
        rdq.push_back(r);
    endtask

    task automatic step(int st, bit rdy, logic [5:0] op, logic z);
        @(negedge clk_i);
        opcode_i6   = op;
        zero_i      = z;
        mem_ready_i = rdy;
        #1;
        chk($sformatf("state op=%b", op), 32'(state_o4), 32'(st));
        chk($sformatf("outs st=%0d op=%b z=%b rdy=%b", st, op, z, rdy), 32'(outv), 32'(exp_out(st, op, z, rdy)));
    endtask

    // Expected state walk for one instruction, with memory stalls.
    task automatic run_instr(logic [5:0] op, logic z, int sf, int sm);
        seq.delete();
        rdq.delete();
        repeat (sf) push(0, 1'b0);
        push(0, 1'b1);
        push(1, 1'($urandom));
        case (op)
            OP_LW: begin
                push(2, 1'($urandom));
                repeat (sm) push(3, 1'b0);
                push(3, 1'b1);
                push(4, 1'($urandom));
            end
            OP_SW: begin
                push(2, 1'($urandom));
                repeat (sm) push(5, 1'b0);
                push(5, 1'b1);
            end
            OP_R:           begin push(6, 1'($urandom)); push(7, 1'($urandom)); end
            OP_BEQ, OP_BNE: push(8, 1'($urandom));
            OP_ADDI:        begin push(9, 1'($urandom)); push(10, 1'($urandom)); end
            OP_J:           push(11, 1'($urandom));
            default: ;
        endcase
        foreach (seq[i]) step(seq[i], rdq[i], op, z);
        if (legal(op)) exp_cnt = (exp_cnt + 1) % 16;
        @(negedge clk_i);
        mem_ready_i = 1'b0;
        #1;
        chk("back_in_fetch", 32'(state_o4), 32'd0);
        chk($sformatf("instr_cnt op=%b", op), 32'(instr_cnt_o), 32'(exp_cnt));
    endtask

    initial begin
        logic [5:0] ops[7];
        logic [5:0] op;
        ops = '{OP_R, OP_LW, OP_SW, OP_BEQ, OP_BNE, OP_ADDI, OP_J};
        reset_ni    = 1'b0;
        mem_ready_i = 1'b1;
        opcode_i6   = OP_LW;
        zero_i      = 1'b0;
        #12;
        chk("reset_state", 32'(state_o4), 32'd0);
        chk("reset_cnt", 32'(instr_cnt_o), 32'd0);
        chk("reset_outs", 32'(outv), 32'(exp_out(0, OP_LW, 1'b0, 1'b1)));
        @(negedge clk_i);
        mem_ready_i = 1'b0;
        reset_ni    = 1'b1;

        run_instr(OP_LW, 1'b0, 0, 0);
        run_instr(OP_SW, 1'b0, 0, 3);
        run_instr(OP_BEQ, 1'b1, 0, 0);
        run_instr(OP_BEQ, 1'b0, 1, 0);
        run_instr(OP_BNE, 1'b0, 0, 0);
        run_instr(OP_BNE, 1'b1, 0, 0);
        run_instr(OP_R, 1'b0, 0, 0);
        run_instr(OP_ADDI, 1'b0, 2, 0);
        run_instr(OP_J, 1'b0, 0, 0);
        run_instr(6'b111111, 1'b0, 0, 0);
        run_instr(OP_LW, 1'b1, 2, 2);

        // Abort a stalled store by asserting reset mid-cycle.
        step(0, 1'b1, OP_SW, 1'b0);
        step(1, 1'b1, OP_SW, 1'b0);
        step(2, 1'b1, OP_SW, 1'b0);
        step(5, 1'b0, OP_SW, 1'b0);
        #2;
        reset_ni = 1'b0;
        #1;
        exp_cnt = 0;
        chk("abort_state", 32'(state_o4), 32'd0);
        chk("abort_mem_we", 32'(mem_we_o), 32'd0);
        chk("abort_cnt", 32'(instr_cnt_o), 32'd0);
        mem_ready_i = 1'b1;
        @(posedge clk_i);
        #1;
        chk("inreset_state", 32'(state_o4), 32'd0);
        chk("inreset_pc_we", 32'(pc_we_o), 32'd1);
        chk("inreset_instr_we", 32'(instr_we_o), 32'd1);
        @(negedge clk_i);
        mem_ready_i = 1'b0;
        reset_ni    = 1'b1;

        repeat (16) run_instr(OP_J, 1'b0, 0, 0);

        repeat (60) begin
            if ($urandom_range(7) == 0) begin
                op = 6'($urandom);
                while (legal(op)) op = 6'($urandom);
            end else begin
                op = ops[$urandom_range(6)];
            end
            run_instr(op, 1'($urandom), $urandom_range(2), $urandom_range(3));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
